// File: rtl/rv32i_mem_responder_if.sv
// CPU-side load/store bus between an RV32I core and the memory responder.
// The master drives requests and accepts responses; the slave is the responder.
interface rv32i_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rv32i_mem_responder.sv
// Word-organised data memory answering RV32I loads/stores with a fixed number
// of wait states, byte/halfword lane handling and error reporting.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1 unless in reset)
// WAIT  | counting down added access cycles
// RESP  | response held on rsp_* until rsp_ready
module rv32i_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input logic                   sys_clk,
    input logic                   sys_reset,
    rv32i_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        acc_we;
    logic [2:0]  acc_f3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic        acc_err;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wd_rep;
    logic [31:0] merged;
    logic        enter_resp;
    logic        mem_we;

    assign bus.req_ready = (state_q == IDLE) && !sys_reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // With zero wait states the access happens on the accept edge itself,
    // so the access path looks straight at the bus while idle.
    always_comb begin
        acc_we    = we_q;
        acc_f3    = funct3_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_f3    = bus.req_funct3;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end
        acc_idx = acc_addr[AW+1:2];

        acc_err = 1'b0;
        if (acc_we && (acc_f3[2] || acc_f3[1:0] == 2'b11))
            acc_err = 1'b1;
        if (!acc_we && (acc_f3 == 3'b011 || acc_f3[2:1] == 2'b11))
            acc_err = 1'b1;
        if (acc_f3[1:0] == 2'b01 && acc_addr[0])
            acc_err = 1'b1;
        if (acc_f3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00)
            acc_err = 1'b1;
        if ({1'b0, acc_addr} >= BYTE_LIMIT)
            acc_err = 1'b1;

        rd_word = acc_err ? 32'h0 : mem_q[acc_idx];
        rd_byte = rd_word[8*acc_addr[1:0] +: 8];
        rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_f3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = rd_word;
        endcase

        case (acc_f3[1:0])
            2'b00:   begin be = 4'b0001 << acc_addr[1:0]; wd_rep = {4{acc_wdata[7:0]}}; end
            2'b01:   begin be = acc_addr[1] ? 4'b1100 : 4'b0011; wd_rep = {2{acc_wdata[15:0]}}; end
            default: begin be = 4'b1111; wd_rep = acc_wdata; end
        endcase
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = be[i] ? wd_rep[8*i +: 8] : rd_word[8*i +: 8];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) enter_resp = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d = RESP;
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'h0 : load_data;
            mem_we  = acc_we && !acc_err;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately not reset; reset only blocks a pending commit.
    always_ff @(posedge sys_clk) begin
        if (mem_we && !sys_reset)
            mem_q[acc_idx] <= merged;
    end
endmodule

// File: tb/tb_rv32i_mem_responder.sv
// Directed self-checking bench for rv32i_mem_responder (WAIT_STATES=1, 1024 words).
module tb_rv32i_mem_responder;
    localparam int WS = 1;
    localparam logic [7:0] LAT = 8'(WS + 1);

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    logic sys_clk;
    logic sys_reset;
    int   checks = 0;
    int   errors = 0;

    rv32i_mem_responder_if bus ();

    rv32i_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .bus       (bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request starting at a negedge and returns at a negedge in IDLE.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output logic [7:0] lat, output logic to);
        int n;
        to = 1'b0; rd = 32'h0; er = 1'b0; lat = 8'd0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd; bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        if (!bus.req_ready) to = 1'b1;
        @(posedge sys_clk);
        #1 bus.req_valid = 1'b0;
        if (!to) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge sys_clk);
                lat++;
                if (bus.rsp_valid) break;
            end
            if (!bus.rsp_valid) to = 1'b1;
            else begin
                rd = bus.rsp_rdata;
                er = bus.rsp_err;
            end
            @(posedge sys_clk);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
        sys_reset = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b exp all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        bus.req_valid = 1'b0;
        sys_reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", bus.req_ready);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_word();
        vec_t v [2];
        logic [31:0] rd; logic er, to; logic [7:0] lat;
        v[0] = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        v[1] = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        for (int i = 0; i < 2; i++) begin
            xact(v[i].we, v[i].f3, v[i].addr, v[i].wd, rd, er, lat, to);
            checks++;
            if ({to, er, rd, lat} !== {1'b0, v[i].err, v[i].rd, LAT}) begin
                errors++;
                $display("FAIL word[%0d] got to=%b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                         i, to, er, rd, lat, v[i].err, v[i].rd, LAT);
            end
        end
    endtask

    task automatic test_byte();
        vec_t v [6];
        logic [31:0] rd; logic er, to; logic [7:0] lat;
        v[0] = '{1'b1, 3'b000, 32'h11, 32'h00000080, 1'b0, 32'h0};
        v[1] = '{1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFF80};
        v[2] = '{1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h00000080};
        v[3] = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD80EF};
        v[4] = '{1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF};
        v[5] = '{1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000DE};
        for (int i = 0; i < 6; i++) begin
            xact(v[i].we, v[i].f3, v[i].addr, v[i].wd, rd, er, lat, to);
            checks++;
            if ({to, er, rd, lat} !== {1'b0, v[i].err, v[i].rd, LAT}) begin
                errors++;
                $display("FAIL byte[%0d] got to=%b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                         i, to, er, rd, lat, v[i].err, v[i].rd, LAT);
            end
        end
    endtask

    task automatic test_half();
        vec_t v [6];
        logic [31:0] rd; logic er, to; logic [7:0] lat;
        v[0] = '{1'b1, 3'b001, 32'h12, 32'hFFFF1234, 1'b0, 32'h0};
        v[1] = '{1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h00001234};
        v[2] = '{1'b0, 3'b001, 32'h13, 32'h0, 1'b1, 32'h0};
        v[3] = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h123480EF};
        v[4] = '{1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFF80EF};
        v[5] = '{1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'h00001234};
        for (int i = 0; i < 6; i++) begin
            xact(v[i].we, v[i].f3, v[i].addr, v[i].wd, rd, er, lat, to);
            checks++;
            if ({to, er, rd, lat} !== {1'b0, v[i].err, v[i].rd, LAT}) begin
                errors++;
                $display("FAIL half[%0d] got to=%b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                         i, to, er, rd, lat, v[i].err, v[i].rd, LAT);
            end
        end
    endtask

    task automatic test_errors();
        vec_t v [14];
        logic [31:0] rd; logic er, to; logic [7:0] lat;
        v[0]  = '{1'b1, 3'b010, 32'h1000, 32'h11111111, 1'b1, 32'h0};
        v[1]  = '{1'b1, 3'b010, 32'hFFC,  32'hA5A5A5A5, 1'b0, 32'h0};
        v[2]  = '{1'b0, 3'b010, 32'hFFC,  32'h0, 1'b0, 32'hA5A5A5A5};
        v[3]  = '{1'b0, 3'b001, 32'hFFE,  32'h0, 1'b0, 32'hFFFFA5A5};
        v[4]  = '{1'b0, 3'b010, 32'h1000, 32'h0, 1'b1, 32'h0};
        v[5]  = '{1'b0, 3'b011, 32'h10,   32'h0, 1'b1, 32'h0};
        v[6]  = '{1'b0, 3'b110, 32'h10,   32'h0, 1'b1, 32'h0};
        v[7]  = '{1'b1, 3'b100, 32'h10,   32'h0, 1'b1, 32'h0};
        v[8]  = '{1'b1, 3'b011, 32'h10,   32'h0, 1'b1, 32'h0};
        v[9]  = '{1'b1, 3'b010, 32'h12,   32'hFFFFFFFF, 1'b1, 32'h0};
        v[10] = '{1'b1, 3'b001, 32'h11,   32'hFFFFFFFF, 1'b1, 32'h0};
        v[11] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0};
        v[12] = '{1'b0, 3'b010, 32'h10,   32'h0, 1'b0, 32'h123480EF};
        v[13] = '{1'b0, 3'b000, 32'h4000_0010, 32'h0, 1'b1, 32'h0};
        for (int i = 0; i < 14; i++) begin
            xact(v[i].we, v[i].f3, v[i].addr, v[i].wd, rd, er, lat, to);
            checks++;
            if ({to, er, rd, lat} !== {1'b0, v[i].err, v[i].rd, LAT}) begin
                errors++;
                $display("FAIL err[%0d] got to=%b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                         i, to, er, rd, lat, v[i].err, v[i].rd, LAT);
            end
        end
    endtask

    // Response held under backpressure while a second request waits on the bus.
    task automatic test_backpressure();
        int n;
        logic [7:0] lat;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
        @(posedge sys_clk);
        #1 bus.req_addr = 32'hFFC;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.rsp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err} !== {2'b10, 32'h123480EF, 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d] got valid=%b ready=%b rdata=%h err=%b exp valid=1 ready=0 rdata=123480ef err=0",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err);
            end
            @(negedge sys_clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got valid=%b ready=%b exp valid=0 ready=1",
                     bus.rsp_valid, bus.req_ready);
        end
        @(posedge sys_clk);
        #1 bus.req_valid = 1'b0;
        lat = 8'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            lat++;
            if (bus.rsp_valid) break;
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, lat} !== {1'b1, 32'hA5A5A5A5, LAT}) begin
            errors++;
            $display("FAIL queued_req got valid=%b rdata=%h lat=%0d exp valid=1 rdata=a5a5a5a5 lat=%0d",
                     bus.rsp_valid, bus.rsp_rdata, lat, LAT);
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, to; logic [7:0] lat;
        xact(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat, to);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h00000055; bus.rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1 bus.req_valid = 1'b0;
        @(negedge sys_clk);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err} !== 35'h0) begin
            errors++;
            $display("FAIL abort_in_reset got valid=%b ready=%b rdata=%h err=%b exp all 0",
                     bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err);
        end
        sys_reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b exp 1", bus.req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_rsp[%0d] got valid=%b exp 0", i, bus.rsp_valid);
            end
        end
        xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, to);
        checks++;
        if ({to, er, rd, lat} !== {1'b0, 1'b0, 32'hCAFEF00D, LAT}) begin
            errors++;
            $display("FAIL abort_readback got to=%b err=%b rdata=%h lat=%0d exp err=0 rdata=cafef00d lat=%0d",
                     to, er, rd, lat, LAT);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
        sys_reset = 1'b1;
        @(negedge sys_clk);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
